v810_bus_ctl: RTL

External bus cycle controller for the V810 core. Snoops the bus outputs of the memory access unit (A, BCYSTn, DAn, MRQn) and generates READYn and SZRQn back to it. Each access is decoded into one of eight memory regions or the I/O space, and the matching entry of a register-programmable table sets its wait states, 16-bit dynamic sizing and external-ready extension. A watchdog bounds externally extended cycles and latches a bus-error flag.

---
 rtl/v810_bus_ctl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/v810_bus_ctl.sv
// V810 external bus cycle controller.
// Watches the memory access unit's bus outputs and returns READYn/SZRQn.
// Each access is decoded to a region entry that sets its wait states,
// 16-bit sizing and external-ready extension. A watchdog bounds externally
// extended cycles and raises a sticky bus-error flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no bus cycle in flight, READYn/SZRQn high
// WAIT   | counting programmed wait states down to zero
// XWAIT  | wait count expired, holding for XRDYn or the watchdog
module v810_bus_ctl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [31:0] A,
    input  logic        BCYSTn,
    input  logic        DAn,
    input  logic        MRQn,
    input  logic        XRDYn,
    output logic        READYn,
    output logic        SZRQn,
    input  logic        CFGWR,
    input  logic [3:0]  CFGSEL,
    input  logic [4:0]  CFGD,
    output logic [4:0]  CFGQ,
    output logic        BERR,
    input  logic        BERRCLR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_XWAIT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIM   = 8'(TIMEOUT);
    localparam logic [4:0] CFG_RESET = 5'b00111;
    localparam logic [3:0] SEL_IO    = 4'd8;

    logic [4:0] cfg_tbl [0:8];

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] tmo, tmo_nxt;
    logic       cur_b16, cur_b16_nxt;
    logic       cur_x, cur_x_nxt;

    logic [3:0] start_sel;
    logic [4:0] start_ent;
    logic       rdy_core_n;
    logic       berr_set;

    // Only the region field of the address takes part in decoding.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^{A[31:27], A[23:0]};

    // Entry of the access being started; read before any same-edge write lands.
    assign start_sel = MRQn ? SEL_IO : {1'b0, A[26:24]};
    assign start_ent = cfg_tbl[start_sel];

    // Config table: reset defaults, writes to unused selects are dropped.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            for (int i = 0; i < 9; i++) begin
                cfg_tbl[i] <= CFG_RESET;
            end
        end else if (CE && CFGWR && (CFGSEL <= SEL_IO)) begin
            cfg_tbl[CFGSEL] <= CFGD;
        end
    end

    // Readback of the selected entry, zero for unused selects.
    always_comb begin
        CFGQ = '0;
        if (CFGSEL <= SEL_IO) begin
            CFGQ = cfg_tbl[CFGSEL];
        end
    end

    // Ready from registered state and XRDYn only; DAn gates it below.
    always_comb begin
        rdy_core_n = 1'b1;
        case (state)
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    rdy_core_n = cur_x ? XRDYn : 1'b0;
                end
            end
            ST_XWAIT: rdy_core_n = XRDYn & (tmo != TMO_LIM);
            default:  rdy_core_n = 1'b1;
        endcase
    end

    assign READYn = rdy_core_n | DAn;
    assign SZRQn  = ~((state != ST_IDLE) & cur_b16 & ~DAn);

    // Next-state: a start restarts from any state and wins over completion.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tmo_nxt     = tmo;
        cur_b16_nxt = cur_b16;
        cur_x_nxt   = cur_x;
        if (!BCYSTn) begin
            state_nxt   = ST_WAIT;
            cnt_nxt     = start_ent[2:0];
            tmo_nxt     = '0;
            cur_b16_nxt = start_ent[3];
            cur_x_nxt   = start_ent[4];
        end else if (!DAn) begin
            if (!READYn) begin
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (cnt != 3'd0) begin
                            cnt_nxt = cnt - 3'd1;
                        end else if (cur_x) begin
                            state_nxt = ST_XWAIT;
                        end
                    end
                    ST_XWAIT: begin
                        // Saturate at the limit so a 255 limit cannot wrap.
                        if (XRDYn && (tmo != TMO_LIM)) begin
                            tmo_nxt = tmo + 8'd1;
                        end
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Cycle state registers, advanced only on enabled edges.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tmo     <= '0;
            cur_b16 <= 1'b0;
            cur_x   <= 1'b0;
        end else if (CE) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tmo     <= tmo_nxt;
            cur_b16 <= cur_b16_nxt;
            cur_x   <= cur_x_nxt;
        end
    end

    // Watchdog-forced completion is the only source of a bus error.
    assign berr_set = (state == ST_XWAIT) & ~DAn & (tmo == TMO_LIM);

    // Sticky bus-error flag; a set on the same edge beats a clear.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            BERR <= 1'b0;
        end else if (CE) begin
            if (berr_set) begin
                BERR <= 1'b1;
            end else if (BERRCLR) begin
                BERR <= 1'b0;
            end
        end
    end

endmodule
